// File: rtl/arc_ucode_pkg.sv
// Shared definitions for the ARC microprogrammed control unit: microword layout,
// next-address condition encodings and the instruction-decode address mapping.
package arc_ucode_pkg;

    localparam int MICROSEQ_ADDR_W = 11;
    localparam int MICROSEQ_WORD_W = 41;
    localparam int MICROSEQ_IR_W   = 32;

    typedef enum logic [2:0] {
        COND_NEXT   = 3'b000,
        COND_N      = 3'b001,
        COND_Z      = 3'b010,
        COND_V      = 3'b011,
        COND_C      = 3'b100,
        COND_IR13   = 3'b101,
        COND_JUMP   = 3'b110,
        COND_DECODE = 3'b111
    } cond_e;

    // Microword field MSB positions (width implied by the -: slices in the top level)
    localparam int UW_A_MSB    = 40;
    localparam int UW_AMUX_BIT = 34;
    localparam int UW_B_MSB    = 33;
    localparam int UW_BMUX_BIT = 27;
    localparam int UW_C_MSB    = 26;
    localparam int UW_CMUX_BIT = 20;
    localparam int UW_RD_BIT   = 19;
    localparam int UW_WR_BIT   = 18;
    localparam int UW_ALU_MSB  = 17;
    localparam int UW_COND_MSB = 13;
    localparam int UW_JUMP_MSB = 10;

    localparam logic [MICROSEQ_ADDR_W-1:0] CS_FETCH_ADDR = 11'h000;

    // Opcode dispatch: op (IR[31:30]) and op3 (IR[24:19]) select a 4-word slot in the upper half
    function automatic logic [MICROSEQ_ADDR_W-1:0] decode_addr(input logic [MICROSEQ_IR_W-1:0] ir);
        return {1'b1, ir[31:30], ir[24:19], 2'b00};
    endfunction

endpackage

// File: rtl/micro_next_addr.sv
// Combinational next control-store address select: increment, conditional jump on
// a PSR flag or IR[13], unconditional jump, or opcode decode.
module micro_next_addr
    import arc_ucode_pkg::*;
(
    input  logic [MICROSEQ_ADDR_W-1:0] csar,
    input  logic [2:0]                 cond,
    input  logic [MICROSEQ_ADDR_W-1:0] jump,
    input  logic [MICROSEQ_IR_W-1:0]   ir,
    input  logic                       flag_n,
    input  logic                       flag_z,
    input  logic                       flag_v,
    input  logic                       flag_c,
    output logic [MICROSEQ_ADDR_W-1:0] next_addr
);

    logic                       take_jump;
    logic [MICROSEQ_ADDR_W-1:0] incr_addr;
    logic                       ir_unused;

    // Only op, op3 and the i-bit of the IR steer sequencing
    assign ir_unused = ^{ir[29:25], ir[18:14], ir[12:0]};

    // Natural 11-bit wrap from 11'h7FF back to the fetch address
    assign incr_addr = csar + 11'd1;

    always_comb begin
        take_jump = 1'b0;
        next_addr = incr_addr;
        case (cond_e'(cond))
            COND_NEXT:   take_jump = 1'b0;
            COND_N:      take_jump = flag_n;
            COND_Z:      take_jump = flag_z;
            COND_V:      take_jump = flag_v;
            COND_C:      take_jump = flag_c;
            COND_IR13:   take_jump = ir[13];
            COND_JUMP:   take_jump = 1'b1;
            default:     take_jump = 1'b0;
        endcase
        if (cond_e'(cond) == COND_DECODE) begin
            next_addr = decode_addr(ir);
        end else if (take_jump) begin
            next_addr = jump;
        end
    end

endmodule

// File: rtl/micro_sequencer.sv
// Control-store address register and microword field split for the ARC CPU;
// the next address comes from micro_next_addr and is held while memory stalls.
module micro_sequencer
    import arc_ucode_pkg::*;
(
    input  logic                       MICROSEQ_CLOCK_50,
    input  logic                       MICROSEQ_RESET_InHigh,
    output logic [MICROSEQ_ADDR_W-1:0] MICROSEQ_ROMAddr_Out,
    input  logic [MICROSEQ_WORD_W-1:0] MICROSEQ_ROMWord_In,
    input  logic [MICROSEQ_IR_W-1:0]   MICROSEQ_IR_In,
    input  logic                       MICROSEQ_FlagN_In,
    input  logic                       MICROSEQ_FlagZ_In,
    input  logic                       MICROSEQ_FlagV_In,
    input  logic                       MICROSEQ_FlagC_In,
    input  logic                       MICROSEQ_Stall_In,
    output logic [5:0]                 MICROSEQ_A_Out,
    output logic                       MICROSEQ_AMUX_Out,
    output logic [5:0]                 MICROSEQ_B_Out,
    output logic                       MICROSEQ_BMUX_Out,
    output logic [5:0]                 MICROSEQ_C_Out,
    output logic                       MICROSEQ_CMUX_Out,
    output logic                       MICROSEQ_RD_Out,
    output logic                       MICROSEQ_WR_Out,
    output logic [3:0]                 MICROSEQ_ALU_Out,
    output logic                       MICROSEQ_Fetch_Out
);

    logic [MICROSEQ_ADDR_W-1:0] csar_q, csar_d;
    logic                       fetch_q, fetch_d;
    logic [MICROSEQ_ADDR_W-1:0] next_addr;
    logic [MICROSEQ_WORD_W-1:0] uword;

    assign uword = MICROSEQ_ROMWord_In;

    micro_next_addr u_next_addr (
        .csar      (csar_q),
        .cond      (uword[UW_COND_MSB -: 3]),
        .jump      (uword[UW_JUMP_MSB -: MICROSEQ_ADDR_W]),
        .ir        (MICROSEQ_IR_In),
        .flag_n    (MICROSEQ_FlagN_In),
        .flag_z    (MICROSEQ_FlagZ_In),
        .flag_v    (MICROSEQ_FlagV_In),
        .flag_c    (MICROSEQ_FlagC_In),
        .next_addr (next_addr)
    );

    always_comb begin
        csar_d  = csar_q;
        fetch_d = 1'b0;
        if (!MICROSEQ_Stall_In) begin
            csar_d  = next_addr;
            fetch_d = (next_addr == CS_FETCH_ADDR);
        end
    end

    always_ff @(posedge MICROSEQ_CLOCK_50 or posedge MICROSEQ_RESET_InHigh) begin
        if (MICROSEQ_RESET_InHigh) begin
            csar_q  <= CS_FETCH_ADDR;
            fetch_q <= 1'b0;
        end else begin
            csar_q  <= csar_d;
            fetch_q <= fetch_d;
        end
    end

    assign MICROSEQ_ROMAddr_Out = csar_q;
    assign MICROSEQ_Fetch_Out   = fetch_q;

    assign MICROSEQ_A_Out    = uword[UW_A_MSB -: 6];
    assign MICROSEQ_AMUX_Out = uword[UW_AMUX_BIT];
    assign MICROSEQ_B_Out    = uword[UW_B_MSB -: 6];
    assign MICROSEQ_BMUX_Out = uword[UW_BMUX_BIT];
    assign MICROSEQ_C_Out    = uword[UW_C_MSB -: 6];
    assign MICROSEQ_CMUX_Out = uword[UW_CMUX_BIT];
    assign MICROSEQ_RD_Out   = uword[UW_RD_BIT];
    // A write must not reach memory while the access is still pending
    assign MICROSEQ_WR_Out   = uword[UW_WR_BIT] & ~MICROSEQ_Stall_In;
    assign MICROSEQ_ALU_Out  = uword[UW_ALU_MSB -: 4];

endmodule

// File: tb/tb_micro_sequencer.sv
// Bench for micro_sequencer: a behavioural ROM plus directed scenarios and a
// randomized run compared against an arithmetic next-address reference model.
module tb_micro_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] rom_addr;
    logic [40:0] rom_word;
    logic [31:0] ir;
    logic        fn, fz, fv, fc, stall;
    logic [5:0]  a_o, b_o, c_o;
    logic        amux_o, bmux_o, cmux_o, rd_o, wr_o, fetch_o;
    logic [3:0]  alu_o;

    logic [40:0] rom [0:2047];
    assign rom_word = rom[rom_addr];

    always #5 clk = ~clk;

    micro_sequencer dut (
        .MICROSEQ_CLOCK_50     (clk),
        .MICROSEQ_RESET_InHigh (rst),
        .MICROSEQ_ROMAddr_Out  (rom_addr),
        .MICROSEQ_ROMWord_In   (rom_word),
        .MICROSEQ_IR_In        (ir),
        .MICROSEQ_FlagN_In     (fn),
        .MICROSEQ_FlagZ_In     (fz),
        .MICROSEQ_FlagV_In     (fv),
        .MICROSEQ_FlagC_In     (fc),
        .MICROSEQ_Stall_In     (stall),
        .MICROSEQ_A_Out        (a_o),
        .MICROSEQ_AMUX_Out     (amux_o),
        .MICROSEQ_B_Out        (b_o),
        .MICROSEQ_BMUX_Out     (bmux_o),
        .MICROSEQ_C_Out        (c_o),
        .MICROSEQ_CMUX_Out     (cmux_o),
        .MICROSEQ_RD_Out       (rd_o),
        .MICROSEQ_WR_Out       (wr_o),
        .MICROSEQ_ALU_Out      (alu_o),
        .MICROSEQ_Fetch_Out    (fetch_o)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [40:0] mk_word(input int cond, input int jump, input bit wr);
        logic [40:0] w;
        w = '0;
        w[13:11] = 3'(cond);
        w[10:0]  = 11'(jump);
        w[18]    = wr;
        return w;
    endfunction

    // Reference: the next address from the sequencing rules, using integer arithmetic
    function automatic int model_next(input int pc, input logic [40:0] w, input bit n, input bit z,
                                      input bit v, input bit c, input logic [31:0] irv);
        int  cond;
        int  jump;
        bit  taken;
        cond = int'(w[13:11]);
        jump = int'(w[10:0]);
        if (cond == 7)
            return 1024 + int'(irv[31:30]) * 256 + int'(irv[24:19]) * 4;
        case (cond)
            1:       taken = n;
            2:       taken = z;
            3:       taken = v;
            4:       taken = c;
            5:       taken = irv[13];
            6:       taken = 1'b1;
            default: taken = 1'b0;
        endcase
        return taken ? jump : (pc + 1) % 2048;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic goto_addr(input int target);
        do_reset();
        rom[0] = mk_word(6, target, 1'b0);
        step();
        rom[0] = '0;
    endtask

    logic [40:0] w;
    logic [26:0] exp_fields;
    int          exp_pc, nxt;
    bit          exp_fetch;

    initial begin
        rst = 1'b1; ir = '0; fn = 0; fz = 0; fv = 0; fc = 0; stall = 0;
        for (int i = 0; i < 2048; i++) rom[i] = '0;

        // Reset state and plain increments from the fetch address
        #3;
        check_val("reset_addr", 64'(rom_addr), 64'h0);
        check_val("reset_fetch", 64'(fetch_o), 64'h0);
        do_reset();
        step();
        check_val("seq_addr1", 64'(rom_addr), 64'h1);
        check_val("seq_fetch1", 64'(fetch_o), 64'h0);
        step();
        check_val("seq_addr2", 64'(rom_addr), 64'h2);
        $display("txn seq: addr=%0h fetch=%0b", rom_addr, fetch_o);

        // Unconditional jump to the top of the store, then wrap to fetch
        goto_addr(5);
        check_val("goto5", 64'(rom_addr), 64'h5);
        rom[5] = mk_word(6, 11'h7FF, 1'b0);
        step();
        check_val("jump_7ff", 64'(rom_addr), 64'h7FF);
        check_val("jump_fetch", 64'(fetch_o), 64'h0);
        step();
        check_val("wrap_addr", 64'(rom_addr), 64'h0);
        check_val("wrap_fetch", 64'(fetch_o), 64'h1);
        step();
        check_val("post_wrap_fetch", 64'(fetch_o), 64'h0);
        rom[5] = '0;
        $display("txn wrap: addr=%0h fetch=%0b", rom_addr, fetch_o);

        // Opcode decode dispatch
        goto_addr(32'h20);
        rom[32'h20] = mk_word(7, 0, 1'b0);
        ir = '0; ir[31:30] = 2'b11; ir[24:19] = 6'b000100;
        step();
        check_val("decode_710", 64'(rom_addr), 64'h710);
        goto_addr(32'h20);
        ir = '0; ir[31:30] = 2'b10; ir[24:19] = 6'b010000;
        step();
        check_val("decode_640", 64'(rom_addr), 64'h640);
        $display("txn decode: addr=%0h", rom_addr);
        rom[32'h20] = '0;

        // Conditional branches on each flag and IR[13], others held opposite
        for (int cnd = 1; cnd <= 5; cnd++) begin
            for (int val = 0; val <= 1; val++) begin
                goto_addr(8);
                rom[8] = mk_word(cnd, 32'hC, 1'b0);
                fn = !val; fz = !val; fv = !val; fc = !val; ir = '0; ir[13] = !val;
                case (cnd)
                    1: fn = val[0];
                    2: fz = val[0];
                    3: fv = val[0];
                    4: fc = val[0];
                    default: ir[13] = val[0];
                endcase
                step();
                check_val($sformatf("cond%0d_val%0d", cnd, val), 64'(rom_addr), val ? 64'hC : 64'h9);
                $display("txn cond=%0d sel=%0d: addr=%0h", cnd, val, rom_addr);
            end
        end
        rom[8] = '0; fn = 0; fz = 0; fv = 0; fc = 0; ir = '0;

        // Stall holds CSAR and masks WR
        goto_addr(32'h28);
        rom[32'h28] = mk_word(0, 0, 1'b1);
        stall = 1'b1;
        #1;
        check_val("stall_wr", 64'(wr_o), 64'h0);
        for (int k = 0; k < 3; k++) begin
            step();
            check_val("stall_hold", 64'(rom_addr), 64'h28);
            check_val("stall_wr_hold", 64'(wr_o), 64'h0);
        end
        stall = 1'b0;
        #1;
        check_val("unstall_wr", 64'(wr_o), 64'h1);
        step();
        check_val("unstall_addr", 64'(rom_addr), 64'h29);
        rom[32'h28] = '0;
        $display("txn stall: addr=%0h", rom_addr);

        // Asynchronous reset mid-cycle wins over stall
        goto_addr(32'hD);
        stall = 1'b1;
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_val("async_rst_addr", 64'(rom_addr), 64'h0);
        check_val("async_rst_fetch", 64'(fetch_o), 64'h0);
        stall = 1'b0;
        $display("txn async_reset: addr=%0h fetch=%0b", rom_addr, fetch_o);

        // Randomized run against the reference model
        for (int i = 0; i < 2048; i++) rom[i] = {9'($urandom), $urandom};
        do_reset();
        exp_pc = 0;
        for (int i = 0; i < 400; i++) begin
            stall = ($urandom_range(0, 3) == 0);
            fn = 1'($urandom); fz = 1'($urandom); fv = 1'($urandom); fc = 1'($urandom);
            ir = $urandom;
            #1;
            w = rom[exp_pc];
            exp_fields = w[40:14];
            if (stall) exp_fields[4] = 1'b0;
            check_val("rnd_fields",
                      64'({a_o, amux_o, b_o, bmux_o, c_o, cmux_o, rd_o, wr_o, alu_o}),
                      64'(exp_fields));
            nxt       = stall ? exp_pc : model_next(exp_pc, w, fn, fz, fv, fc, ir);
            exp_fetch = !stall && (nxt == 0);
            step();
            exp_pc = nxt;
            check_val("rnd_addr", 64'(rom_addr), 64'(exp_pc));
            check_val("rnd_fetch", 64'(fetch_o), 64'(exp_fetch));
            $display("txn rnd %0d: stall=%0b addr=%0h fetch=%0b", i, stall, rom_addr, fetch_o);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
